// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive byte buffer between the UART receiver and the CPU
// register interface. The read port pops on the falling edge of the CPU read
// strobe, RTS follows fill level with hysteresis, and dropped bytes raise a
// sticky overflow flag.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int RTS_HIGH   = 12,
  parameter int RTS_LOW    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_strobe,
  input  logic                  rd_req,
  input  logic                  flush,
  input  logic                  ovf_clr,
  output logic [7:0]            dout,
  output logic                  data_avail,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  rts_n
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LP_DEPTH = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LP_HIGH  = (DEPTH_LOG2 + 1)'(RTS_HIGH);
  localparam logic [DEPTH_LOG2:0] LP_LOW   = (DEPTH_LOG2 + 1)'(RTS_LOW);

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_ovf;
  logic                  r_rts_n;
  logic                  r_rd_req_d;

  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [DEPTH_LOG2:0]   w_level_nxt;
  logic                  w_rts_nxt;
  logic                  w_ovf_nxt;

  // Decode this cycle's push/pop/drop events and the resulting occupancy.
  always_comb begin
    w_empty     = (r_level == '0);
    // The pop fires once the CPU read finishes, so dout holds through the read.
    w_pop       = r_rd_req_d & ~rd_req & ~w_empty;
    // A full FIFO still accepts a byte when a slot is freed in the same cycle.
    w_push      = rx_strobe & ((r_level < LP_DEPTH) | w_pop);
    w_drop      = rx_strobe & ~w_push;
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
    // A drop wins over a simultaneous clear so the loss is never hidden.
    w_ovf_nxt = r_ovf;
    if (ovf_clr) w_ovf_nxt = 1'b0;
    if (w_drop)  w_ovf_nxt = 1'b1;
    // Hysteresis between the two thresholds, judged on the upcoming level.
    w_rts_nxt = r_rts_n;
    if (w_level_nxt >= LP_HIGH)     w_rts_nxt = 1'b1;
    else if (w_level_nxt <= LP_LOW) w_rts_nxt = 1'b0;
  end

  // Pointer, level, flag and flow-control state; flush clears it synchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_ovf      <= 1'b0;
      r_rts_n    <= 1'b0;
      r_rd_req_d <= 1'b0;
    end else begin
      r_rd_req_d <= rd_req;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
        r_ovf    <= 1'b0;
        r_rts_n  <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        r_level <= w_level_nxt;
        r_ovf   <= w_ovf_nxt;
        r_rts_n <= w_rts_nxt;
      end
    end
  end

  // Byte storage; contents are meaningful only where the level says so.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= rx_byte;
  end

  // Head byte is read combinationally and forced to zero when empty.
  always_comb begin
    dout       = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    data_avail = ~w_empty;
    overflow   = r_ovf;
    level      = r_level;
    rts_n      = r_rts_n;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: queue-based reference model checked against the FIFO on
// every falling clock edge, plus directed sequences with literal expectations.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_strobe = 1'b0;
  logic       rd_req = 1'b0;
  logic       flush = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] dout;
  logic       data_avail;
  logic       overflow;
  logic [4:0] level;
  logic       rts_n;

  int total = 0;
  int bad   = 0;

  uart_rx_fifo #(.DEPTH_LOG2(4), .RTS_HIGH(12), .RTS_LOW(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_strobe(rx_strobe),
    .rd_req(rd_req), .flush(flush), .ovf_clr(ovf_clr), .dout(dout),
    .data_avail(data_avail), .overflow(overflow), .level(level), .rts_n(rts_n)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of bytes plus flags, derived from the behaviour rules.
  logic [7:0] q[$];
  bit m_ovf  = 1'b0;
  bit m_rts  = 1'b0;
  bit m_prev = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ovf  = 1'b0;
      m_rts  = 1'b0;
      m_prev = 1'b0;
    end else begin
      bit rd_done;
      bit was_full;
      rd_done  = m_prev && !rd_req && (q.size() > 0);
      was_full = (q.size() == 16);
      if (flush) begin
        q.delete();
        m_ovf = 1'b0;
        m_rts = 1'b0;
      end else begin
        if (rd_done) void'(q.pop_front());
        if (ovf_clr) m_ovf = 1'b0;
        if (rx_strobe) begin
          if (!was_full || rd_done) q.push_back(rx_byte);
          else m_ovf = 1'b1;
        end
        if (q.size() >= 12) m_rts = 1'b1;
        else if (q.size() <= 4) m_rts = 1'b0;
      end
      m_prev = rd_req;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("m_dout",  {24'h0, dout}, (q.size() > 0) ? {24'h0, q[0]} : 32'h0);
    chk("m_avail", {31'h0, data_avail}, (q.size() > 0) ? 32'd1 : 32'd0);
    chk("m_ovf",   {31'h0, overflow}, {31'h0, m_ovf});
    chk("m_level", {27'h0, level}, q.size());
    chk("m_rts",   {31'h0, rts_n}, {31'h0, m_rts});
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_strobe = 1'b1;
    rx_byte   = b;
    idle(1);
    rx_strobe = 1'b0;
  endtask

  task automatic pop();
    rd_req = 1'b1;
    idle(2);
    rd_req = 1'b0;
    idle(1);
  endtask

  initial begin
    // Reset state.
    idle(2);
    chk("rst_level", {27'h0, level}, 0);
    chk("rst_dout",  {24'h0, dout}, 8'h00);
    chk("rst_avail", {31'h0, data_avail}, 0);
    chk("rst_ovf",   {31'h0, overflow}, 0);
    chk("rst_rts",   {31'h0, rts_n}, 0);
    rst_n = 1'b1;
    idle(1);

    // Single byte becomes visible one cycle after the push.
    push(8'hA5);
    chk("a5_avail", {31'h0, data_avail}, 1);
    chk("a5_dout",  {24'h0, dout}, 8'hA5);
    chk("a5_level", {27'h0, level}, 1);
    chk("a5_rts",   {31'h0, rts_n}, 0);
    pop();
    chk("a5_empty", {27'h0, level}, 0);

    // Read timing: head held for the whole read, advances after the fall.
    push(8'h01); push(8'h02); push(8'h03);
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("rd_hold", {24'h0, dout}, 8'h01);
    end
    rd_req = 1'b0;
    chk("rd_fall", {24'h0, dout}, 8'h01);
    idle(1);
    chk("rd_next", {24'h0, dout}, 8'h02);
    chk("rd_lvl2", {27'h0, level}, 2);
    pop();
    chk("rd_third", {24'h0, dout}, 8'h03);
    pop();
    chk("rd_empty_dout",  {24'h0, dout}, 8'h00);
    chk("rd_empty_avail", {31'h0, data_avail}, 0);
    pop();
    chk("rd_empty_pop", {27'h0, level}, 0);

    // Fill, RTS high threshold, overflow and its clear priority.
    for (int i = 0; i < 11; i++) push(8'h10 + 8'(i));
    chk("fill11_rts", {31'h0, rts_n}, 0);
    push(8'h1B);
    chk("fill12_rts", {31'h0, rts_n}, 1);
    for (int i = 12; i < 16; i++) push(8'h10 + 8'(i));
    chk("full_level", {27'h0, level}, 16);
    push(8'hFF);
    chk("ovf_set",   {31'h0, overflow}, 1);
    chk("ovf_level", {27'h0, level}, 16);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", {31'h0, overflow}, 0);
    ovf_clr = 1'b1;
    push(8'hFE);
    ovf_clr = 1'b0;
    chk("ovf_drop_wins", {31'h0, overflow}, 1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;

    // Push on a full FIFO in the same cycle as a pop; wraps the pointers.
    rd_req = 1'b1;
    idle(2);
    rd_req    = 1'b0;
    rx_strobe = 1'b1;
    rx_byte   = 8'h77;
    idle(1);
    rx_strobe = 1'b0;
    chk("pp_level", {27'h0, level}, 16);
    chk("pp_ovf",   {31'h0, overflow}, 0);
    chk("pp_head",  {24'h0, dout}, 8'h11);
    for (int i = 0; i < 11; i++) pop();
    chk("hyst5_level", {27'h0, level}, 5);
    chk("hyst5_rts",   {31'h0, rts_n}, 1);
    pop();
    chk("hyst4_rts",   {31'h0, rts_n}, 0);
    chk("hyst4_dout",  {24'h0, dout}, 8'h1D);
    for (int i = 0; i < 3; i++) pop();
    chk("wrap_77", {24'h0, dout}, 8'h77);
    chk("wrap_lvl", {27'h0, level}, 1);
    pop();

    // Flush discards contents and a coincident push; read spanning it is inert.
    push(8'h31); push(8'h32);
    rd_req    = 1'b1;
    flush     = 1'b1;
    rx_strobe = 1'b1;
    rx_byte   = 8'h33;
    idle(1);
    flush     = 1'b0;
    rx_strobe = 1'b0;
    chk("flush_level", {27'h0, level}, 0);
    chk("flush_dout",  {24'h0, dout}, 8'h00);
    idle(1);
    rd_req = 1'b0;
    idle(2);
    chk("flush_nopop", {27'h0, level}, 0);

    // Asynchronous reset in the middle of a read with RTS asserted.
    for (int i = 0; i < 12; i++) push(8'h40 + 8'(i));
    for (int i = 0; i < 3; i++) pop();
    chk("pre_rst_level", {27'h0, level}, 9);
    chk("pre_rst_rts",   {31'h0, rts_n}, 1);
    rd_req = 1'b1;
    idle(1);
    rst_n = 1'b0;
    #1;
    chk("arst_level", {27'h0, level}, 0);
    chk("arst_dout",  {24'h0, dout}, 8'h00);
    chk("arst_rts",   {31'h0, rts_n}, 0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    rd_req = 1'b0;
    idle(2);
    chk("arst_nopop", {27'h0, level}, 0);
    push(8'h5C);
    chk("arst_after", {24'h0, dout}, 8'h5C);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
